// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// datapath widths and the PC step.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_e;

  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {pc, instruction} pairs between fetch and decode.
// Flush empties it in one edge and overrides any push or pop.
module fetch_buf
  import fetch_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [31:0]       i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [1:0]        o_count
);

  logic [31:0]       r_pc_q   [2];
  logic [INST_W-1:0] r_inst_q [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_pc    = r_pc_q[r_rd_ptr];
  assign o_inst  = r_inst_q[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_pc_q[i]   <= '0;
        r_inst_q[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_pc_q[r_wr_ptr]   <= i_pc;
        r_inst_q[r_wr_ptr] <= i_inst;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and FSM, addresses the external IM and
// feeds the returned words into a 2-entry buffer consumed by decode.
module fetch_ctrl
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [IM_AW-1:0]  addresIM,
  input  logic [INST_W-1:0] im_inst,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic              halted,
  output logic              fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_target;
  logic         w_redirect;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_buf_valid;
  logic [1:0]   w_count;

  assign addresIM   = r_pc[IM_AW+1:2];
  assign w_redirect = jump | branch_taken;
  assign w_target   = jump ? jump_target : branch_target;
  assign w_pop      = w_buf_valid & out_ready;
  assign out_valid  = w_buf_valid & (r_state != ST_FAULT);
  assign halted     = (r_state == ST_HALTED);
  assign fault      = (r_state == ST_FAULT);

  // Priority inside RUN/HALTED: redirect (faulting or not) > halt > push.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_RUN;
      ST_RUN, ST_HALTED: begin
        if (w_redirect) begin
          w_flush = 1'b1;
          if (!is_word_aligned(w_target[1:0])) begin
            w_state_next = ST_FAULT;
          end else begin
            w_pc_next = w_target;
          end
        end else if (r_state == ST_HALTED) begin
          if (!halt) w_state_next = ST_RUN;
        end else if (halt) begin
          w_state_next = ST_HALTED;
        end else if ((w_count < 2'd2) || w_pop) begin
          w_push    = 1'b1;
          w_pc_next = r_pc + PC_INC;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_pc    (r_pc),
    .i_inst  (im_inst),
    .o_valid (w_buf_valid),
    .o_pc    (out_pc),
    .o_inst  (out_inst),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, directed corner
// sequences and random stimulus against a queue-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addresIM;
  logic [31:0] im_inst;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;

  logic [31:0] im_mem [32];

  always #5 clk = ~clk;
  assign im_inst = im_mem[addresIM];

  fetch_ctrl #(.RESET_PC(RST_PC), .IM_AW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addresIM      (addresIM),
    .im_inst       (im_inst),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .halted        (halted),
    .fault         (fault)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of fetched words, a PC and a coarse mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  int          mst;

  typedef struct {
    logic        rst_n;
    logic        j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic        h;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halted;
    logic        e_fault;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return im_mem[a[6:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic h, input logic rdy);
    rst_n = r; jump = j; jump_target = jt; branch_taken = b;
    branch_target = bt; halt = h; out_ready = rdy;
  endtask

  task automatic model_step();
    logic        pop;
    logic [31:0] tgt;
    if (!rst_n) begin
      mq.delete();
      mpc = RST_PC;
      mst = M_IDLE;
      return;
    end
    case (mst)
      M_IDLE: mst = M_RUN;
      M_RUN, M_HALT: begin
        pop = (mq.size() > 0) && out_ready;
        tgt = jump ? jump_target : branch_target;
        if (pop) mq.delete(0);
        if (jump || branch_taken) begin
          mq.delete();
          if (tgt[1:0] != 2'b00) mst = M_FAULT;
          else mpc = tgt;
        end else if (mst == M_HALT) begin
          if (!halt) mst = M_RUN;
        end else if (halt) begin
          mst = M_HALT;
        end else if (mq.size() < 2) begin
          mq.push_back('{mpc, im_word(mpc)});
          mpc = mpc + 32'd4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    chk("valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
    chk("halted", 32'(halted), 32'(mst == M_HALT));
    chk("fault", 32'(fault), 32'(mst == M_FAULT));
    chk("addresIM", 32'(addresIM), 32'(mpc[6:2]));
  endtask

  task automatic edge_only();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    edge_only();
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_inst"}, out_inst, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_addr"}, 32'(addresIM), 32'(RST_PC[6:2]));
  endtask

  initial begin
    logic [4:0]  frozen_addr;
    logic [31:0] frozen_pc;
    logic [31:0] rt;

    for (int i = 0; i < 32; i++) im_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0013);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Vector table: inputs for one edge, expected outputs after it.
    vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1});
    vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 1'b0});

    foreach (vq[k]) begin
      drive(vq[k].rst_n, vq[k].j, vq[k].jt, vq[k].b, vq[k].bt, vq[k].h, vq[k].rdy);
      edge_only();
      chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vq[k].e_valid));
      if (vq[k].e_valid) begin
        chk($sformatf("vec%0d_pc", k), out_pc, vq[k].e_pc);
        chk($sformatf("vec%0d_inst", k), out_inst, im_word(vq[k].e_pc));
      end
      chk($sformatf("vec%0d_halted", k), 32'(halted), 32'(vq[k].e_halted));
      chk($sformatf("vec%0d_fault", k), 32'(fault), 32'(vq[k].e_fault));
    end

    // Streaming from reset with out_ready held: PC walks past the IM wrap.
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    check_reset_values("rst_a");
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 34; k++) begin
      step();
      chk("stream_pc", out_pc, RST_PC + 32'(4 * k));
      chk("stream_addr", 32'(addresIM), 32'((k + 1) % 32));
    end

    // Backpressure: buffer fills, then reset lands while it is full.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("full_count", 32'(mq.size()), 32'd2);
    rst_n = 1'b0;
    step();
    check_reset_values("rst_b");
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("e0_valid", 32'(out_valid), 32'd0);
    step();
    chk("e1_valid", 32'(out_valid), 32'd1);
    chk("e1_pc", out_pc, RST_PC);

    // PC wraps modulo 2^32.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    jump = 1'b0;
    step();
    chk("wrap_top", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", out_pc, 32'h0000_0000);

    // Halt for four cycles: PC/IM address frozen, fetch resumes there.
    halt = 1'b1;
    step();
    frozen_addr = addresIM;
    frozen_pc   = mpc;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt_addr", 32'(addresIM), 32'(frozen_addr));
      chk("halt_flag", 32'(halted), 32'd1);
    end
    halt = 1'b0;
    step();
    step();
    chk("resume_pc", out_pc, frozen_pc);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rt = $urandom;
      if ($urandom_range(31) != 0) rt[1:0] = 2'b00;
      rst_n         = ($urandom_range(99) != 0);
      jump          = ($urandom_range(19) == 0);
      jump_target   = rt;
      branch_taken  = ($urandom_range(15) == 0);
      branch_target = {$urandom_range(255), 2'b00};
      if ($urandom_range(19) == 0) halt = ~halt;
      out_ready     = ($urandom_range(3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
